// File: rtl/aurora_rx_channel_if.sv
// aurora_rx_channel_if: decoded-lane input, payload stream and link status of the Aurora RX channel
interface aurora_rx_channel_if #(parameter int DATA_SIZE = 16);
   logic                 rx_valid;
   logic [DATA_SIZE-1:0] rx_data;
   logic [1:0]           rx_ctrl;
   logic                 rx_code_err;
   logic                 axi_valid;
   logic                 axi_last;
   logic [DATA_SIZE-1:0] axi_data;
   logic                 simplex_aligned;
   logic                 simplex_verified;
   logic                 channel_up;
   logic                 frame_err;
   modport master (
      output rx_valid, rx_data, rx_ctrl, rx_code_err,
      input  axi_valid, axi_last, axi_data, simplex_aligned, simplex_verified, channel_up, frame_err
   );
   modport slave (
      input  rx_valid, rx_data, rx_ctrl, rx_code_err,
      output axi_valid, axi_last, axi_data, simplex_aligned, simplex_verified, channel_up, frame_err
   );
endinterface

// File: rtl/aurora_rx_channel.sv
// aurora_rx_channel: Aurora simplex RX channel-init FSM (align/verify/up) and ordered-set stripping framer
module aurora_rx_channel #(
   parameter int DATA_SIZE    = 16,
   parameter int ALIGN_COUNT  = 8,
   parameter int VERIFY_COUNT = 4,
   parameter int ERR_LIMIT    = 3
) (
   input logic                clk,
   input logic                rst,
   aurora_rx_channel_if.slave lane
);
   localparam int CW = $clog2(ALIGN_COUNT + VERIFY_COUNT + 1);
   localparam int EW = $clog2(ERR_LIMIT + 1);
   typedef enum logic [1:0] {ALIGN, VERIFY, UP} state_t;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [EW-1:0]        err_q, err_d;
   logic                 in_frame_q, in_frame_d;
   logic                 hold_vld_q, hold_vld_d;
   logic [DATA_SIZE-1:0] hold_q, hold_d;
   logic [DATA_SIZE-1:0] out_data_q, out_data_d;
   logic                 out_vld_q, out_vld_d;
   logic                 out_last_q, out_last_d;
   logic                 frame_err_q, frame_err_d;
   logic [7:0]           b1, b0;
   logic                 ok_k, is_comma, is_v, is_scp, is_ecp, is_idle, is_data, is_ok, err_hit, rel;
   function automatic logic idle_byte(input logic [7:0] b);
      return b == 8'hBC || b == 8'h1C || b == 8'h7C;
   endfunction
   assign b1       = lane.rx_data[DATA_SIZE-1 -: 8];
   assign b0       = lane.rx_data[7:0];
   assign ok_k     = lane.rx_ctrl == 2'b11 && !lane.rx_code_err;
   assign is_comma = lane.rx_ctrl[1] && b1 == 8'hBC && !lane.rx_code_err;
   assign is_v     = ok_k && b1 == 8'hBC && b0 == 8'hE8;
   assign is_scp   = ok_k && b1 == 8'h5C && b0 == 8'hFB;
   assign is_ecp   = ok_k && b1 == 8'hFD && b0 == 8'hFE;
   assign is_idle  = ok_k && idle_byte(b1) && idle_byte(b0);
   assign is_data  = lane.rx_ctrl == 2'b00 && !lane.rx_code_err;
   assign is_ok    = is_v || is_scp || is_ecp || is_idle || is_data;
   assign err_hit  = !is_ok && err_q == EW'(ERR_LIMIT - 1);
   // the held word is only released by a word that proves the frame continues or ends
   assign rel      = in_frame_q && hold_vld_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ALIGN;
         cnt_q       <= '0;
         err_q       <= '0;
         in_frame_q  <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_q      <= '0;
         out_data_q  <= '0;
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         in_frame_q  <= in_frame_d;
         hold_vld_q  <= hold_vld_d;
         hold_q      <= hold_d;
         out_data_q  <= out_data_d;
         out_vld_q   <= out_vld_d;
         out_last_q  <= out_last_d;
         frame_err_q <= frame_err_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      in_frame_d  = in_frame_q;
      hold_vld_d  = hold_vld_q;
      hold_d      = hold_q;
      out_vld_d   = 1'b0;
      out_last_d  = 1'b0;
      frame_err_d = 1'b0;
      if (lane.rx_valid) begin
         case (state_q)
            ALIGN: begin
               cnt_d = is_comma ? cnt_q + 1'b1 : '0;
               if (is_comma && cnt_q == CW'(ALIGN_COUNT - 1)) begin
                  state_d = VERIFY;
                  cnt_d   = '0;
                  err_d   = '0;
               end
            end
            VERIFY: begin
               cnt_d = is_v ? cnt_q + 1'b1 : '0;
               err_d = is_ok ? '0 : err_q + 1'b1;
               if (is_v && cnt_q == CW'(VERIFY_COUNT - 1)) begin
                  state_d = UP;
                  cnt_d   = '0;
               end else if (err_hit) begin
                  state_d = ALIGN;
                  cnt_d   = '0;
                  err_d   = '0;
               end
            end
            UP: begin
               err_d = is_ok ? '0 : err_q + 1'b1;
               if (err_hit) begin
                  state_d     = ALIGN;
                  err_d       = '0;
                  in_frame_d  = 1'b0;
                  hold_vld_d  = 1'b0;
                  frame_err_d = in_frame_q;
               end else if (is_scp) begin
                  in_frame_d  = 1'b1;
                  hold_vld_d  = 1'b0;
                  frame_err_d = in_frame_q;
                  out_vld_d   = rel;
                  out_last_d  = rel;
               end else if (is_ecp) begin
                  in_frame_d  = 1'b0;
                  hold_vld_d  = 1'b0;
                  frame_err_d = !in_frame_q;
                  out_vld_d   = rel;
                  out_last_d  = rel;
               end else if (is_data) begin
                  frame_err_d = !in_frame_q;
                  out_vld_d   = rel;
                  hold_d      = in_frame_q ? lane.rx_data : hold_q;
                  hold_vld_d  = in_frame_q;
               end
            end
            default: state_d = ALIGN;
         endcase
      end
      out_data_d = out_vld_d ? hold_q : out_data_q;
   end
   assign lane.axi_valid        = out_vld_q;
   assign lane.axi_last         = out_last_q;
   assign lane.axi_data         = out_data_q;
   assign lane.frame_err        = frame_err_q;
   assign lane.simplex_aligned  = state_q != ALIGN;
   assign lane.simplex_verified = state_q == UP;
   assign lane.channel_up       = state_q == UP;
endmodule

// File: tb/tb_aurora_rx_channel.sv
// tb_aurora_rx_channel: directed vectors for the Aurora RX channel FSM and framer
module tb_aurora_rx_channel;
   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          ferr_n = 0;
   logic [16:0] beats[$];
   aurora_rx_channel_if #(.DATA_SIZE(16)) bus ();
   aurora_rx_channel dut (.clk(clk), .rst(rst), .lane(bus));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.axi_valid) beats.push_back({bus.axi_last, bus.axi_data});
      if (bus.frame_err) ferr_n++;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_beat(input string tag, input int idx, input logic [16:0] exp);
      check(tag, idx < beats.size() ? 32'(beats[idx]) : 32'hFFFF_FFFF, 32'(exp));
   endtask
   task automatic word(input logic [15:0] d, input logic [1:0] c, input logic e);
      @(negedge clk);
      bus.rx_valid    = 1'b1;
      bus.rx_data     = d;
      bus.rx_ctrl     = c;
      bus.rx_code_err = e;
      @(posedge clk);
      #1 bus.rx_valid = 1'b0;
   endtask
   task automatic kw();  word(16'hBC1C, 2'b11, 1'b0); endtask
   task automatic vw();  word(16'hBCE8, 2'b11, 1'b0); endtask
   task automatic scp(); word(16'h5CFB, 2'b11, 1'b0); endtask
   task automatic ecp(); word(16'hFDFE, 2'b11, 1'b0); endtask
   task automatic bad(); word(16'h0000, 2'b00, 1'b1); endtask
   task automatic dat(input logic [15:0] d); word(d, 2'b00, 1'b0); endtask
   task automatic idle(); @(posedge clk); #1; endtask
   task automatic bring_up();
      repeat (8) kw();
      repeat (4) vw();
   endtask
   task automatic do_reset();
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      idle();
      idle();
      rst = 1'b0;
   endtask
   initial begin
      int b, f;
      bus.rx_valid    = 1'b0;
      bus.rx_data     = '0;
      bus.rx_ctrl     = '0;
      bus.rx_code_err = 1'b0;
      do_reset();
      check("rst_aligned", 32'(bus.simplex_aligned), 0);
      check("rst_verified", 32'(bus.simplex_verified), 0);
      check("rst_up", 32'(bus.channel_up), 0);
      check("rst_valid", 32'(bus.axi_valid), 0);
      check("rst_ferr", 32'(bus.frame_err), 0);
      // bring-up thresholds
      repeat (7) kw();
      check("t1_aligned_7k", 32'(bus.simplex_aligned), 0);
      kw();
      check("t1_aligned_8k", 32'(bus.simplex_aligned), 1);
      check("t1_verified_8k", 32'(bus.simplex_verified), 0);
      repeat (3) vw();
      check("t1_up_3v", 32'(bus.channel_up), 0);
      vw();
      check("t1_up_4v", 32'(bus.channel_up), 1);
      check("t1_verified_4v", 32'(bus.simplex_verified), 1);
      // three-word frame with latency and hold checks
      b = beats.size();
      f = ferr_n;
      scp();
      dat(16'h1111);
      check("t2_held_valid", 32'(bus.axi_valid), 0);
      dat(16'h2222);
      check("t2_lat_valid", 32'(bus.axi_valid), 1);
      check("t2_lat_data", 32'(bus.axi_data), 32'h1111);
      check("t2_lat_last", 32'(bus.axi_last), 0);
      dat(16'h3333);
      ecp();
      check("t2_end_valid", 32'(bus.axi_valid), 1);
      check("t2_end_last", 32'(bus.axi_last), 1);
      check("t2_end_data", 32'(bus.axi_data), 32'h3333);
      idle();
      check("t2_idle_valid", 32'(bus.axi_valid), 0);
      check("t2_idle_last", 32'(bus.axi_last), 0);
      check("t2_idle_data", 32'(bus.axi_data), 32'h3333);
      check("t2_count", 32'(beats.size() - b), 3);
      check_beat("t2_b0", b, 17'h0_1111);
      check_beat("t2_b1", b + 1, 17'h0_2222);
      check_beat("t2_b2", b + 2, 17'h1_3333);
      check("t2_ferr", 32'(ferr_n - f), 0);
      // idle inside a frame is clock compensation
      b = beats.size();
      f = ferr_n;
      scp();
      dat(16'hAAAA);
      kw();
      dat(16'hBBBB);
      ecp();
      idle();
      check("t3_count", 32'(beats.size() - b), 2);
      check_beat("t3_b0", b, 17'h0_AAAA);
      check_beat("t3_b1", b + 1, 17'h1_BBBB);
      check("t3_ferr", 32'(ferr_n - f), 0);
      check("t3_up", 32'(bus.channel_up), 1);
      // SCP inside a frame closes the open frame
      b = beats.size();
      f = ferr_n;
      scp();
      dat(16'h1234);
      scp();
      dat(16'h5678);
      ecp();
      idle();
      check("t4_count", 32'(beats.size() - b), 2);
      check_beat("t4_b0", b, 17'h1_1234);
      check_beat("t4_b1", b + 1, 17'h1_5678);
      check("t4_ferr", 32'(ferr_n - f), 1);
      // out-of-frame ECP/data and empty frame
      b = beats.size();
      f = ferr_n;
      ecp();
      dat(16'h9999);
      scp();
      ecp();
      idle();
      check("t4b_count", 32'(beats.size() - b), 0);
      check("t4b_ferr", 32'(ferr_n - f), 2);
      // a valid word between invalid words keeps the link up
      b = beats.size();
      f = ferr_n;
      scp();
      dat(16'h00A1);
      bad();
      bad();
      dat(16'h00A2);
      bad();
      bad();
      check("t4c_up", 32'(bus.channel_up), 1);
      ecp();
      idle();
      check("t4c_count", 32'(beats.size() - b), 2);
      check_beat("t4c_b0", b, 17'h0_00A1);
      check_beat("t4c_b1", b + 1, 17'h1_00A2);
      check("t4c_ferr", 32'(ferr_n - f), 0);
      // three consecutive code errors drop the link mid-frame
      b = beats.size();
      f = ferr_n;
      scp();
      dat(16'h0001);
      bad();
      bad();
      check("t5_up_2err", 32'(bus.channel_up), 1);
      bad();
      check("t5_up_3err", 32'(bus.channel_up), 0);
      check("t5_aligned", 32'(bus.simplex_aligned), 0);
      idle();
      check("t5_count", 32'(beats.size() - b), 0);
      check("t5_ferr", 32'(ferr_n - f), 1);
      // broken comma run restarts alignment; async reset mid-VERIFY
      do_reset();
      repeat (7) kw();
      dat(16'h1234);
      repeat (7) kw();
      check("t6_aligned_run", 32'(bus.simplex_aligned), 0);
      kw();
      check("t6_aligned_8", 32'(bus.simplex_aligned), 1);
      repeat (2) vw();
      #2 rst = 1'b1;
      #1;
      check("t6_rst_aligned", 32'(bus.simplex_aligned), 0);
      check("t6_rst_verified", 32'(bus.simplex_verified), 0);
      idle();
      rst = 1'b0;
      // idle in VERIFY restarts the /V/ run
      repeat (8) kw();
      repeat (3) vw();
      kw();
      repeat (3) vw();
      check("t6_vrestart_up", 32'(bus.channel_up), 0);
      vw();
      check("t6_vrestart_up4", 32'(bus.channel_up), 1);
      // errors in VERIFY drop back to ALIGN
      do_reset();
      repeat (8) kw();
      bad();
      bad();
      check("t6_verr2_aligned", 32'(bus.simplex_aligned), 1);
      bad();
      check("t6_verr3_aligned", 32'(bus.simplex_aligned), 0);
      // reset mid-frame clears outputs at once and discards the frame
      do_reset();
      bring_up();
      scp();
      dat(16'h4444);
      dat(16'h5555);
      check("t6_pre_valid", 32'(bus.axi_valid), 1);
      check("t6_pre_data", 32'(bus.axi_data), 32'h4444);
      #2 rst = 1'b1;
      #1;
      check("t6_mid_valid", 32'(bus.axi_valid), 0);
      check("t6_mid_up", 32'(bus.channel_up), 0);
      idle();
      rst = 1'b0;
      b = beats.size();
      f = ferr_n;
      bring_up();
      ecp();
      idle();
      check("t6_post_count", 32'(beats.size() - b), 0);
      check("t6_post_ferr", 32'(ferr_n - f), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
